// File: rtl/sa3_job_arbiter.sv
// rtl/sa3_job_arbiter.sv - round-robin job arbiter/sequencer for a shared 3x3 systolic array
//
// Two requesters share one systolic_array_3_by_3. One job at a time: the
// winner's 4x4 patch and 3x3 filter are latched, the array is cleared for one
// cycle, run until done (or timeout), and the 2x2 result is returned to the
// owner over a valid/ready response.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req[1:0]            per-requester job request (held until gnt)
//   req0_a, req1_a      128-bit row-major 4x4 patch (a11 at [7:0])
//   req0_b, req1_b      72-bit row-major 3x3 filter (b11 at [7:0])
//   gnt[1:0]            one-cycle one-hot pulse: operands latched
//   rsp_valid[1:0]      one-hot result available
//   rsp_ready[1:0]      per-requester response accept
//   rsp_c               {c22, c21, c12, c11}
//   rsp_err             job timed out (rsp_c is 0)
//   sa_a, sa_b          operands to the array
//   sa_active           array run enable
//   sa_clr              active-high array reset
//   sa_done, sa_c       array done flag and result

module sa3_job_arbiter #(
  parameter int TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [127:0] req0_a,
  input  logic [127:0] req1_a,
  input  logic [71:0]  req0_b,
  input  logic [71:0]  req1_b,
  output logic [1:0]   gnt,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [31:0]  rsp_c,
  output logic         rsp_err,
  output logic [127:0] sa_a,
  output logic [71:0]  sa_b,
  output logic         sa_active,
  output logic         sa_clr,
  input  logic         sa_done,
  input  logic [31:0]  sa_c
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

  state_t       state, state_d;
  logic         ptr, ptr_d;
  logic         owner, owner_d;
  logic [5:0]   cnt, cnt_d;
  logic [127:0] a_d;
  logic [71:0]  b_d;
  logic [31:0]  res_d;
  logic         err_d;
  logic [1:0]   gnt_d;
  logic [1:0]   valid_d;
  logic         active_d;

  // The array sits in reset whenever this block does, independent of the clock.
  assign sa_clr = ~rst | (state == CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      cnt       <= '0;
      sa_a      <= '0;
      sa_b      <= '0;
      rsp_c     <= '0;
      rsp_err   <= 1'b0;
      gnt       <= '0;
      rsp_valid <= '0;
      sa_active <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      owner     <= owner_d;
      cnt       <= cnt_d;
      sa_a      <= a_d;
      sa_b      <= b_d;
      rsp_c     <= res_d;
      rsp_err   <= err_d;
      gnt       <= gnt_d;
      rsp_valid <= valid_d;
      sa_active <= active_d;
    end
  end

  // Next-state logic also computes the next value of every registered output,
  // so gnt/sa_active/rsp_valid line up exactly with CLEAR/RUN/RESP.
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    owner_d  = owner;
    cnt_d    = cnt;
    a_d      = sa_a;
    b_d      = sa_b;
    res_d    = rsp_c;
    err_d    = rsp_err;
    gnt_d    = 2'b00;
    valid_d  = rsp_valid;
    active_d = sa_active;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          // Pointer side wins if it asks; otherwise the only other asker does.
          owner_d = req[ptr] ? ptr : ~ptr;
          a_d     = owner_d ? req1_a : req0_a;
          b_d     = owner_d ? req1_b : req0_b;
          gnt_d   = owner_d ? 2'b10 : 2'b01;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        cnt_d    = '0;
        active_d = 1'b1;
        state_d  = RUN;
      end

      RUN: begin
        cnt_d = cnt + 6'd1;
        // Done takes priority over a timeout landing in the same cycle.
        if (sa_done) begin
          res_d    = sa_c;
          err_d    = 1'b0;
          active_d = 1'b0;
          valid_d  = owner ? 2'b10 : 2'b01;
          state_d  = RESP;
        end else if (cnt == CNT_LAST) begin
          res_d    = '0;
          err_d    = 1'b1;
          active_d = 1'b0;
          valid_d  = owner ? 2'b10 : 2'b01;
          state_d  = RESP;
        end
      end

      RESP: begin
        if (rsp_ready[owner]) begin
          ptr_d   = ~owner;
          valid_d = 2'b00;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sa3_job_arbiter.sv
// tb/tb_sa3_job_arbiter.sv - directed self-checking bench for sa3_job_arbiter

module tb_sa3_job_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [127:0] req0_a = '0;
  logic [127:0] req1_a = '0;
  logic [71:0]  req0_b = '0;
  logic [71:0]  req1_b = '0;
  logic [1:0]   gnt;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = 2'b00;
  logic [31:0]  rsp_c;
  logic         rsp_err;
  logic [127:0] sa_a;
  logic [71:0]  sa_b;
  logic         sa_active;
  logic         sa_clr;
  logic         sa_done;
  logic [31:0]  sa_c;

  int checks = 0;
  int errors = 0;

  sa3_job_arbiter #(.TIMEOUT(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req0_a    (req0_a),
    .req1_a    (req1_a),
    .req0_b    (req0_b),
    .req1_b    (req1_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_err   (rsp_err),
    .sa_a      (sa_a),
    .sa_b      (sa_b),
    .sa_active (sa_active),
    .sa_clr    (sa_clr),
    .sa_done   (sa_done),
    .sa_c      (sa_c)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the 3x3 array: 17 active cycles to done,
  // accumulators persist until cleared.
  logic [4:0]  m_cnt;
  logic [31:0] m_acc;
  logic        m_done;
  logic        done_en = 1'b1;

  function automatic logic [31:0] conv_add(input logic [31:0] acc,
                                           input logic [127:0] a,
                                           input logic [71:0] b);
    logic [31:0] r;
    logic [7:0]  s;
    r = acc;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 8'd0;
        for (int m = 0; m < 3; m++)
          for (int n = 0; n < 3; n++)
            s = s + 8'(a[((i + m) * 4 + (j + n)) * 8 +: 8] * b[(m * 3 + n) * 8 +: 8]);
        r[(i * 2 + j) * 8 +: 8] = r[(i * 2 + j) * 8 +: 8] + s;
      end
    return r;
  endfunction

  always @(posedge clk) begin
    if (sa_clr) begin
      m_cnt  <= '0;
      m_done <= 1'b0;
      m_acc  <= '0;
    end else if (sa_active && !m_done) begin
      m_cnt <= m_cnt + 5'd1;
      if (m_cnt == 5'd15 && done_en) begin
        m_done <= 1'b1;
        m_acc  <= conv_add(m_acc, sa_a, sa_b);
      end
    end
  end

  assign sa_done = m_done;
  assign sa_c    = m_acc;

  initial begin
    #1000000;
    $display("FAIL watchdog got running exp finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req       = 2'b00;
    rsp_ready = 2'b00;
    done_en   = 1'b1;
    tick();
    tick();
    check("rst_gnt", gnt, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_c", rsp_c, 0);
    check("rst_err", rsp_err, 0);
    check("rst_active", sa_active, 0);
    check("rst_sa_a", sa_a, 0);
    check("rst_sa_b", sa_b, 0);
    check("rst_clr", sa_clr, 1);
    rst = 1'b1;
    tick();
  endtask

  // Waits for a grant to `who`, then for its response, checks it, accepts it.
  task automatic serve(input string tag, input int who, input logic [31:0] exp_c,
                       input logic exp_err);
    logic [1:0] onehot;
    int n;
    onehot = (who == 1) ? 2'b10 : 2'b01;
    n = 0;
    while (gnt == 2'b00 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_gnt"}, gnt, onehot);
    req[who] = 1'b0;
    n = 0;
    while (rsp_valid == 2'b00 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, rsp_valid, onehot);
    check({tag, "_c"}, rsp_c, exp_c);
    check({tag, "_err"}, rsp_err, exp_err);
    rsp_ready = onehot;
    tick();
    rsp_ready = 2'b00;
  endtask

  initial begin
    // Single job, cycle-exact, then a back-to-back repeat with ready held.
    do_reset();
    req0_a = {16{8'd1}};
    req0_b = {9{8'd1}};
    req    = 2'b01;
    check("c0_gnt", gnt, 0);
    check("c0_clr", sa_clr, 0);
    tick();
    check("c1_gnt", gnt, 2'b01);
    check("c1_clr", sa_clr, 1);
    check("c1_active", sa_active, 0);
    req = 2'b00;
    tick();
    check("c2_gnt", gnt, 0);
    check("c2_clr", sa_clr, 0);
    check("c2_active", sa_active, 1);
    check("c2_sa_a", sa_a, {16{8'd1}});
    check("c2_sa_b", sa_b, {9{8'd1}});
    for (int k = 3; k <= 18; k++) tick();
    check("c18_valid", rsp_valid, 0);
    check("c18_active", sa_active, 1);
    tick();
    check("c19_valid", rsp_valid, 2'b01);
    check("c19_c", rsp_c, 32'h09090909);
    check("c19_err", rsp_err, 0);
    check("c19_active", sa_active, 0);
    rsp_ready = 2'b01;
    req       = 2'b01;
    tick();
    check("c20_valid", rsp_valid, 0);
    check("c20_gnt", gnt, 0);
    tick();
    check("b2b_gnt", gnt, 2'b01);
    req = 2'b00;
    for (int k = 0; k < 18; k++) tick();
    check("b2b_valid", rsp_valid, 2'b01);
    check("b2b_c", rsp_c, 32'h09090909);
    tick();
    rsp_ready = 2'b00;

    // Contention from reset: 0 then 1; then after a solo job by 0, 1 then 0.
    do_reset();
    req0_a = {16{8'd2}};
    req1_a = {16{8'd3}};
    req0_b = {9{8'd1}};
    req1_b = {9{8'd1}};
    req = 2'b11;
    serve("rr_a0", 0, 32'h12121212, 1'b0);
    serve("rr_a1", 1, 32'h1b1b1b1b, 1'b0);
    req = 2'b01;
    serve("rr_solo", 0, 32'h12121212, 1'b0);
    req = 2'b11;
    serve("rr_b1", 1, 32'h1b1b1b1b, 1'b0);
    serve("rr_b0", 0, 32'h12121212, 1'b0);

    // Timeout: no done, response after 32 RUN cycles, then a clean job.
    do_reset();
    done_en = 1'b0;
    req0_a  = {16{8'd1}};
    req     = 2'b01;
    tick();
    check("to_gnt", gnt, 2'b01);
    req = 2'b00;
    for (int k = 2; k <= 33; k++) tick();
    check("to_c33_valid", rsp_valid, 0);
    tick();
    check("to_valid", rsp_valid, 2'b01);
    check("to_err", rsp_err, 1);
    check("to_c", rsp_c, 0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    done_en   = 1'b1;
    req       = 2'b01;
    serve("to_after", 0, 32'h09090909, 1'b0);

    // Backpressure: response held, non-owner ready ignored, no new grant.
    do_reset();
    req0_a = {16{8'd1}};
    req1_a = {16{8'd3}};
    req = 2'b01;
    for (int k = 0; k < 60 && rsp_valid == 2'b00; k++) begin
      tick();
      if (gnt[0]) req[0] = 1'b0;
    end
    req = 2'b10;
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", rsp_valid, 2'b01);
      check("bp_c", rsp_c, 32'h09090909);
      check("bp_gnt", gnt, 0);
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    check("bp_nonowner", rsp_valid, 2'b01);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    check("bp_idle_valid", rsp_valid, 0);
    tick();
    check("bp_next_gnt", gnt, 2'b10);
    serve("bp_next", 1, 32'h1b1b1b1b, 1'b0);

    // Reset in RUN cycle 10: everything drops at once, next job is clean.
    do_reset();
    req0_a = {16{8'd1}};
    req = 2'b01;
    tick();
    req = 2'b00;
    for (int k = 2; k <= 11; k++) tick();
    check("mr_active_pre", sa_active, 1);
    rst = 1'b0;
    #1;
    check("mr_clr", sa_clr, 1);
    check("mr_active", sa_active, 0);
    check("mr_gnt", gnt, 0);
    check("mr_valid", rsp_valid, 0);
    check("mr_sa_a", sa_a, 0);
    check("mr_sa_b", sa_b, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mr_no_rsp", rsp_valid, 0);
    req = 2'b10;
    serve("mr_after", 1, 32'h1b1b1b1b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
